// File: rtl/man_motion_ctrl.sv
// rtl/man_motion_ctrl.sv - running-man horizontal/vertical motion controller
//
// Purpose: steps the man sprite one pixel right per frame-step strobe, wrapping
// onto the next of three floors at the right edge. It handles ground, crouch
// and a fixed-profile jump: ascend, hold at apex, then descend.
//
// Ports:
//   clock      - system clock, rising-edge
//   reset_n    - asynchronous active-low reset
//   update     - frame-step strobe; each high cycle is one step
//   jump_key   - debounced jump button level (rising edge requests a jump)
//   crouch_key - debounced crouch button level
//   x_out      - sprite top-left x
//   y_out      - sprite top-left y
//   man_style  - 1 = normal sprite, 0 = crouch sprite
//   airborne   - high while ascending, at apex or descending
//   pos_valid  - one-cycle pulse after each step
module man_motion_ctrl #(
  parameter int X_MAX       = 153,
  parameter int JUMP_HEIGHT = 12,
  parameter int STEP        = 2,
  parameter int APEX_HOLD   = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       update,
  input  logic       jump_key,
  input  logic       crouch_key,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic       man_style,
  output logic       airborne,
  output logic       pos_valid
);

  localparam logic [2:0] ST_GROUND  = 3'd0;
  localparam logic [2:0] ST_CROUCH  = 3'd1;
  localparam logic [2:0] ST_ASCEND  = 3'd2;
  localparam logic [2:0] ST_APEX    = 3'd3;
  localparam logic [2:0] ST_DESCEND = 3'd4;

  localparam logic [7:0] X_LAST    = 8'(X_MAX);
  localparam logic [3:0] H_TOP     = 4'(JUMP_HEIGHT);
  localparam logic [3:0] H_STEP    = 4'(STEP);
  localparam logic [6:0] Y_STEP    = 7'(STEP);
  localparam logic [3:0] HOLD_LAST = 4'(APEX_HOLD - 1);

  logic [2:0] state, state_nxt;
  logic [1:0] lane, lane_wrap;
  logic [3:0] height, height_nxt;
  logic [3:0] apex_cnt, apex_nxt;
  logic [7:0] x_nxt;
  logic [6:0] y_nxt;
  logic       style_nxt;
  logic       jump_req, key_prev;
  logic       clear_req;
  logic       key_edge;

  // Floor base y: floor top minus the 7-pixel sprite height.
  function automatic logic [6:0] lane_base(input logic [1:0] l);
    case (l)
      2'd0:    lane_base = 7'd28;
      2'd1:    lane_base = 7'd68;
      default: lane_base = 7'd108;
    endcase
  endfunction

  assign lane_wrap = (lane == 2'd2) ? 2'd0 : lane + 2'd1;
  assign key_edge  = jump_key && !key_prev &&
                     ((state == ST_GROUND) || (state == ST_CROUCH));

  // Result of one step; only committed on an update cycle.
  always_comb begin
    state_nxt  = state;
    height_nxt = height;
    apex_nxt   = apex_cnt;
    x_nxt      = x_out;
    y_nxt      = y_out;
    style_nxt  = man_style;
    clear_req  = 1'b0;
    if (x_out >= X_LAST) begin
      // Wrap overrides any vertical motion; a pending jump request survives.
      x_nxt      = 8'd0;
      y_nxt      = lane_base(lane_wrap);
      state_nxt  = ST_GROUND;
      style_nxt  = 1'b1;
      height_nxt = 4'd0;
      apex_nxt   = 4'd0;
    end else begin
      x_nxt = x_out + 8'd1;
      case (state)
        ST_GROUND: begin
          if (jump_req) begin
            clear_req  = 1'b1;
            y_nxt      = lane_base(lane) - Y_STEP;
            height_nxt = H_STEP;
            apex_nxt   = 4'd0;
            state_nxt  = (H_STEP == H_TOP) ? ST_APEX : ST_ASCEND;
          end else if (crouch_key) begin
            state_nxt = ST_CROUCH;
            style_nxt = 1'b0;
            y_nxt     = lane_base(lane);
          end else begin
            y_nxt = lane_base(lane);
          end
        end
        ST_CROUCH: begin
          // A jump requested while crouched is discarded, never taken.
          clear_req = 1'b1;
          if (!crouch_key) begin
            state_nxt = ST_GROUND;
            style_nxt = 1'b1;
          end
        end
        ST_ASCEND: begin
          y_nxt      = y_out - Y_STEP;
          height_nxt = height + H_STEP;
          if (height + H_STEP == H_TOP) begin
            state_nxt = ST_APEX;
            apex_nxt  = 4'd0;
          end
        end
        ST_APEX: begin
          apex_nxt = apex_cnt + 4'd1;
          if (apex_cnt == HOLD_LAST) state_nxt = ST_DESCEND;
        end
        ST_DESCEND: begin
          y_nxt      = y_out + Y_STEP;
          height_nxt = height - H_STEP;
          if (height == H_STEP) begin
            state_nxt = ST_GROUND;
            y_nxt     = lane_base(lane);
          end
        end
        default: begin
          state_nxt  = ST_GROUND;
          y_nxt      = lane_base(lane);
          height_nxt = 4'd0;
          style_nxt  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_GROUND;
      lane      <= 2'd2;
      height    <= 4'd0;
      apex_cnt  <= 4'd0;
      x_out     <= 8'd30;
      y_out     <= 7'd108;
      man_style <= 1'b1;
      airborne  <= 1'b0;
      pos_valid <= 1'b0;
      jump_req  <= 1'b0;
      key_prev  <= 1'b0;
    end else begin
      key_prev  <= jump_key;
      pos_valid <= update;
      if (update) begin
        state     <= state_nxt;
        height    <= height_nxt;
        apex_cnt  <= apex_nxt;
        x_out     <= x_nxt;
        y_out     <= y_nxt;
        man_style <= style_nxt;
        airborne  <= (state_nxt == ST_ASCEND) || (state_nxt == ST_APEX) ||
                     (state_nxt == ST_DESCEND);
        if (x_out >= X_LAST) lane <= lane_wrap;
      end
      // Consumption on a step wins over a simultaneous new key edge.
      if (update && clear_req) jump_req <= 1'b0;
      else if (key_edge)       jump_req <= 1'b1;
    end
  end

endmodule

// File: tb/tb_man_motion_ctrl.sv
// tb/tb_man_motion_ctrl.sv - scoreboard bench for man_motion_ctrl
module tb_man_motion_ctrl;

  localparam int X_MAX       = 153;
  localparam int JUMP_HEIGHT = 12;
  localparam int STEP        = 2;
  localparam int APEX_HOLD   = 2;
  localparam int N_UP        = JUMP_HEIGHT / STEP;
  localparam int T_TOTAL     = 2 * N_UP + APEX_HOLD;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       update, jump_key, crouch_key;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic       man_style, airborne, pos_valid;

  man_motion_ctrl #(
    .X_MAX(X_MAX), .JUMP_HEIGHT(JUMP_HEIGHT), .STEP(STEP), .APEX_HOLD(APEX_HOLD)
  ) dut (
    .clock(clock), .reset_n(reset_n), .update(update), .jump_key(jump_key),
    .crouch_key(crouch_key), .x_out(x_out), .y_out(y_out),
    .man_style(man_style), .airborne(airborne), .pos_valid(pos_valid)
  );

  always #5 clock = ~clock;

  typedef struct { int x; int y; int style; int air; } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: the jump is a trajectory index t (0 = on the floor),
  // height is read off the fixed ascend/hold/descend profile.
  int m_x, m_lane, m_t, m_crouch, m_req, m_kprev, exp_valid;

  function automatic int hgt(input int t);
    if (t <= N_UP) return t * STEP;
    if (t <= N_UP + APEX_HOLD) return JUMP_HEIGHT;
    return JUMP_HEIGHT - (t - N_UP - APEX_HOLD) * STEP;
  endfunction

  task automatic chk(input string name, input int act, input int exp_v);
    n_tests++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_x = 30; m_lane = 2; m_t = 0; m_crouch = 0; m_req = 0; m_kprev = 0;
      exp_valid = 0;
      exp_q.delete();
      cur = '{x: 30, y: 108, style: 1, air: 0};
    end else begin
      int   key_edge, cleared;
      exp_t e;
      key_edge  = (jump_key && !m_kprev && m_t == 0) ? 1 : 0;
      m_kprev   = jump_key;
      exp_valid = update;
      cleared   = 0;
      if (update) begin
        if (m_x >= X_MAX) begin
          m_x = 0; m_lane = (m_lane + 1) % 3; m_t = 0; m_crouch = 0;
        end else begin
          m_x++;
          if (m_t != 0) begin
            m_t++;
            if (m_t == T_TOTAL) m_t = 0;
          end else if (m_crouch) begin
            cleared = 1;
            if (!crouch_key) m_crouch = 0;
          end else if (m_req) begin
            cleared = 1;
            m_t = 1;
          end else if (crouch_key) begin
            m_crouch = 1;
          end
        end
        e.x = m_x;
        e.y = 28 + 40 * m_lane - hgt(m_t);
        e.style = m_crouch ? 0 : 1;
        e.air = (m_t != 0) ? 1 : 0;
        exp_q.push_back(e);
      end
      if (cleared) m_req = 0;
      else if (key_edge) m_req = 1;
    end
  end

  // Monitor: pops an expectation on every pos_valid, checks hold otherwise.
  always @(posedge clock) begin
    #1;
    if (reset_n) begin
      chk("pos_valid", int'(pos_valid), exp_valid);
      if (pos_valid) begin
        if (exp_q.size() == 0) chk("queue_underflow", 1, 0);
        else cur = exp_q.pop_front();
      end
      chk("x_out", int'(x_out), cur.x);
      chk("y_out", int'(y_out), cur.y);
      chk("man_style", int'(man_style), cur.style);
      chk("airborne", int'(airborne), cur.air);
    end
  end

  task automatic step_cycle(input bit u, input bit jk, input bit ck);
    @(negedge clock);
    update = u; jump_key = jk; crouch_key = ck;
  endtask

  task automatic do_step(input bit jk, input bit ck);
    step_cycle(1'b1, jk, ck);
    @(posedge clock);
    #1;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_x"}, int'(x_out), 30);
    chk({tag, "_y"}, int'(y_out), 108);
    chk({tag, "_style"}, int'(man_style), 1);
    chk({tag, "_air"}, int'(airborne), 0);
    chk({tag, "_valid"}, int'(pos_valid), 0);
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge clock);
    update = 1'b0;
    #2 reset_n = 1'b0;
    #1 reset_checks(tag);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  int jump_y[14] = '{106, 104, 102, 100, 98, 96, 96, 96, 98, 100, 102, 104, 106, 108};

  initial begin
    bit jk, ck;
    reset_n = 1'b1; update = 1'b0; jump_key = 1'b0; crouch_key = 1'b0;
    #3 reset_n = 1'b0;
    #1 reset_checks("reset");
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // Five plain steps.
    repeat (5) do_step(1'b0, 1'b0);
    step_cycle(1'b0, 1'b0, 1'b0);
    @(posedge clock); #1;
    chk("walk5_x", int'(x_out), 35);
    chk("walk5_y", int'(y_out), 108);

    // Full jump profile.
    step_cycle(1'b0, 1'b1, 1'b0);
    step_cycle(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) begin
      do_step(1'b0, 1'b0);
      chk($sformatf("jump_y%0d", i), int'(y_out), jump_y[i]);
      chk($sformatf("jump_air%0d", i), int'(airborne), (i < 13) ? 1 : 0);
    end

    // Crouch swallows a jump request.
    do_step(1'b0, 1'b1);
    chk("crouch_style", int'(man_style), 0);
    chk("crouch_y", int'(y_out), 108);
    step_cycle(1'b0, 1'b1, 1'b1);
    do_step(1'b1, 1'b1);
    chk("crouch_hold_style", int'(man_style), 0);
    chk("crouch_hold_air", int'(airborne), 0);
    do_step(1'b0, 1'b0);
    chk("uncrouch_style", int'(man_style), 1);
    do_step(1'b0, 1'b0);
    chk("no_jump_after_crouch", int'(airborne), 0);

    // Edge during descend is ignored.
    step_cycle(1'b0, 1'b1, 1'b0);
    repeat (13) do_step(1'b0, 1'b0);
    step_cycle(1'b0, 1'b1, 1'b0);
    do_step(1'b1, 1'b0);
    chk("land_air", int'(airborne), 0);
    chk("land_y", int'(y_out), 108);
    do_step(1'b0, 1'b0);
    chk("no_rejump_air", int'(airborne), 0);
    chk("no_rejump_y", int'(y_out), 108);

    // Wrap in the middle of an ascent.
    for (int k = 0; k < 300 && m_x != X_MAX - 4; k++) do_step(1'b0, 1'b0);
    chk("wrap_align", m_x, X_MAX - 4);
    step_cycle(1'b0, 1'b1, 1'b0);
    repeat (4) do_step(1'b0, 1'b0);
    chk("pre_wrap_x", int'(x_out), 153);
    chk("pre_wrap_y", int'(y_out), 100);
    do_step(1'b0, 1'b0);
    chk("wrap_x", int'(x_out), 0);
    chk("wrap_y", int'(y_out), 28);
    chk("wrap_air", int'(airborne), 0);
    chk("wrap_style", int'(man_style), 1);

    // Reset in the apex hold.
    step_cycle(1'b0, 1'b1, 1'b0);
    repeat (7) do_step(1'b0, 1'b0);
    chk("apex_y", int'(y_out), 16);
    pulse_reset("apex_reset");
    do_step(1'b0, 1'b0);
    chk("after_reset_x", int'(x_out), 31);
    chk("after_reset_y", int'(y_out), 108);

    // Randomized run.
    jk = 1'b0; ck = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 5) == 0) jk = !jk;
      if ($urandom_range(0, 9) == 0) ck = !ck;
      step_cycle($urandom_range(0, 2) != 0, jk, ck);
      if ($urandom_range(0, 1499) == 0) pulse_reset("rand_reset");
    end
    step_cycle(1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clock);
    #2;
    chk("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
